tl_source_shrinker: RTL and testbench

//  Manager-side adapter directly downstream of the N:1 client socket. Remaps the socket's wide extended
//  A source IDs ({client_id, client_source}) onto a small pool of tags for uncached TL-UL/UH managers.
//  D responses are restored to the original extended source before they return to the socket.

---
 rtl/tl_pkg.sv | 47 ++++
 rtl/tl_tag_freelist.sv | 55 +++++
 rtl/tl_source_shrinker.sv | 180 ++++++++++++++++++
 tb/tb_tl_source_shrinker.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// TileLink opcode constants and beat-count helpers shared by the source shrinker.
package tl_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned SIZE_W   = 4;
  localparam int unsigned BEAT_W   = 16;

  localparam logic [OPCODE_W-1:0] TL_A_PUT_FULL    = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_A_PUT_PARTIAL = 3'd1;
  localparam logic [OPCODE_W-1:0] TL_A_ARITH       = 3'd2;
  localparam logic [OPCODE_W-1:0] TL_A_LOGIC       = 3'd3;
  localparam logic [OPCODE_W-1:0] TL_A_GET         = 3'd4;
  localparam logic [OPCODE_W-1:0] TL_A_INTENT      = 3'd5;

  localparam logic [OPCODE_W-1:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Beats in a data-carrying message of 2**size bytes on a 2**log2_bb byte bus.
  function automatic logic [BEAT_W-1:0] tl_beats(input logic [SIZE_W-1:0] size,
                                                 input logic [SIZE_W-1:0] log2_bb);
    logic [BEAT_W-1:0] beats;
    beats = BEAT_W'(1);
    if (size > log2_bb) beats = BEAT_W'(1) << (size - log2_bb);
    return beats;
  endfunction

  function automatic logic tl_a_has_data(input logic [OPCODE_W-1:0] opcode);
    logic has;
    case (opcode)
      TL_A_PUT_FULL, TL_A_PUT_PARTIAL, TL_A_ARITH, TL_A_LOGIC: has = 1'b1;
      TL_A_GET, TL_A_INTENT:                                   has = 1'b0;
      default:                                                 has = 1'b0;
    endcase
    return has;
  endfunction

  function automatic logic tl_d_has_data(input logic [OPCODE_W-1:0] opcode);
    logic has;
    case (opcode)
      TL_D_ACCESS_ACK:      has = 1'b0;
      TL_D_ACCESS_ACK_DATA: has = 1'b1;
      default:              has = 1'b0;
    endcase
    return has;
  endfunction

endpackage

// File: rtl/tl_tag_freelist.sv
// Tag pool: busy vector, lowest-free allocator and in-flight count.
module tl_tag_freelist #(
  parameter int unsigned TAG_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alloc_en,
  input  logic                    free_en,
  input  logic [TAG_W-1:0]        free_tag,
  output logic [(2**TAG_W)-1:0]   busy_o,
  output logic                    any_free_c,
  output logic [TAG_W-1:0]        alloc_tag_c,
  output logic [TAG_W:0]          inflight_o
);

  localparam int unsigned N_TAGS = 2**TAG_W;

  logic [N_TAGS-1:0] busy_q;
  logic [N_TAGS-1:0] busy_d;
  logic [TAG_W:0]    inflight_q;
  logic [TAG_W:0]    inflight_d;

  // Lowest-index free tag, taken from the registered vector only.
  always_comb begin
    any_free_c  = 1'b0;
    alloc_tag_c = '0;
    for (int unsigned i = 0; i < N_TAGS; i++) begin
      if (!busy_q[i] && !any_free_c) begin
        any_free_c  = 1'b1;
        alloc_tag_c = TAG_W'(i);
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (free_en)  busy_d[free_tag]    = 1'b0;
    if (alloc_en) busy_d[alloc_tag_c] = 1'b1;
    inflight_d = inflight_q + (TAG_W+1)'(alloc_en) - (TAG_W+1)'(free_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      inflight_q <= '0;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
    end
  end

  assign busy_o     = busy_q;
  assign inflight_o = inflight_q;

endmodule

// File: rtl/tl_source_shrinker.sv
// Remaps wide upstream A source IDs onto a small tag pool and restores them on D.
module tl_source_shrinker
  import tl_pkg::*;
#(
  parameter int unsigned IN_SOURCE_W  = 6,
  parameter int unsigned OUT_SOURCE_W = 2,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned ADDR_W       = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // upstream A
  input  logic                    in_a_valid,
  output logic                    in_a_ready,
  input  logic [OPCODE_W-1:0]     in_a_opcode,
  input  logic [2:0]              in_a_param,
  input  logic [SIZE_W-1:0]       in_a_size,
  input  logic [IN_SOURCE_W-1:0]  in_a_source,
  input  logic [ADDR_W-1:0]       in_a_address,
  input  logic [DATA_W/8-1:0]     in_a_mask,
  input  logic [DATA_W-1:0]       in_a_data,
  input  logic                    in_a_corrupt,
  // downstream A
  output logic                    out_a_valid,
  input  logic                    out_a_ready,
  output logic [OPCODE_W-1:0]     out_a_opcode,
  output logic [2:0]              out_a_param,
  output logic [SIZE_W-1:0]       out_a_size,
  output logic [OUT_SOURCE_W-1:0] out_a_source,
  output logic [ADDR_W-1:0]       out_a_address,
  output logic [DATA_W/8-1:0]     out_a_mask,
  output logic [DATA_W-1:0]       out_a_data,
  output logic                    out_a_corrupt,
  // downstream D
  input  logic                    out_d_valid,
  output logic                    out_d_ready,
  input  logic [OPCODE_W-1:0]     out_d_opcode,
  input  logic [2:0]              out_d_param,
  input  logic [SIZE_W-1:0]       out_d_size,
  input  logic [OUT_SOURCE_W-1:0] out_d_source,
  input  logic [3:0]              out_d_sink,
  input  logic                    out_d_denied,
  input  logic [DATA_W-1:0]       out_d_data,
  input  logic                    out_d_corrupt,
  // upstream D
  output logic                    in_d_valid,
  input  logic                    in_d_ready,
  output logic [OPCODE_W-1:0]     in_d_opcode,
  output logic [2:0]              in_d_param,
  output logic [SIZE_W-1:0]       in_d_size,
  output logic [IN_SOURCE_W-1:0]  in_d_source,
  output logic [3:0]              in_d_sink,
  output logic                    in_d_denied,
  output logic [DATA_W-1:0]       in_d_data,
  output logic                    in_d_corrupt,
  // status
  output logic [OUT_SOURCE_W:0]   inflight_o,
  output logic                    err_o
);

  localparam int unsigned N_TAGS  = 2**OUT_SOURCE_W;
  localparam int unsigned LOG2_BB = $clog2(DATA_W/8);

  logic [N_TAGS-1:0]       busy;
  logic                    any_free_c;
  logic [OUT_SOURCE_W-1:0] alloc_tag_c;

  logic                    a_in_burst_q;
  logic [OUT_SOURCE_W-1:0] a_burst_tag_q;
  logic [BEAT_W-1:0]       a_beats_left_q;
  logic [IN_SOURCE_W-1:0]  src_tbl_q [N_TAGS];
  logic [BEAT_W-1:0]       d_cnt_q   [N_TAGS];
  logic                    err_q;

  logic                    a_open;
  logic                    a_fire;
  logic                    a_first;
  logic [BEAT_W-1:0]       a_beats;
  logic                    d_fire;
  logic                    d_tag_busy;
  logic                    d_last;
  logic [BEAT_W-1:0]       d_beats;
  logic                    free_en;

  // A path: follow-on burst beats bypass the free-tag check.
  assign a_open  = a_in_burst_q || any_free_c;
  assign a_fire  = in_a_valid && in_a_ready;
  assign a_first = a_fire && !a_in_burst_q;
  assign a_beats = tl_a_has_data(in_a_opcode) ? tl_beats(in_a_size, SIZE_W'(LOG2_BB))
                                              : BEAT_W'(1);

  assign out_a_valid   = in_a_valid && a_open;
  assign in_a_ready    = out_a_ready && a_open;
  assign out_a_source  = a_in_burst_q ? a_burst_tag_q : alloc_tag_c;
  assign out_a_opcode  = in_a_opcode;
  assign out_a_param   = in_a_param;
  assign out_a_size    = in_a_size;
  assign out_a_address = in_a_address;
  assign out_a_mask    = in_a_mask;
  assign out_a_data    = in_a_data;
  assign out_a_corrupt = in_a_corrupt;

  // D path: always forwarded, source restored from the table.
  assign d_fire     = out_d_valid && in_d_ready;
  assign d_tag_busy = busy[out_d_source];
  assign d_beats    = tl_d_has_data(out_d_opcode) ? tl_beats(out_d_size, SIZE_W'(LOG2_BB))
                                                  : BEAT_W'(1);
  assign d_last     = (d_cnt_q[out_d_source] == (d_beats - BEAT_W'(1)));
  assign free_en    = d_fire && d_tag_busy && d_last;

  assign in_d_valid   = out_d_valid;
  assign out_d_ready  = in_d_ready;
  assign in_d_opcode  = out_d_opcode;
  assign in_d_param   = out_d_param;
  assign in_d_size    = out_d_size;
  assign in_d_source  = src_tbl_q[out_d_source];
  assign in_d_sink    = out_d_sink;
  assign in_d_denied  = out_d_denied;
  assign in_d_data    = out_d_data;
  assign in_d_corrupt = out_d_corrupt;

  tl_tag_freelist #(
    .TAG_W (OUT_SOURCE_W)
  ) u_freelist (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_en    (a_first),
    .free_en     (free_en),
    .free_tag    (out_d_source),
    .busy_o      (busy),
    .any_free_c  (any_free_c),
    .alloc_tag_c (alloc_tag_c),
    .inflight_o  (inflight_o)
  );

  // A burst tracker: holds the tag for the remaining data beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_in_burst_q   <= 1'b0;
      a_burst_tag_q  <= '0;
      a_beats_left_q <= '0;
    end else if (a_fire) begin
      if (!a_in_burst_q) begin
        if (a_beats > BEAT_W'(1)) begin
          a_in_burst_q   <= 1'b1;
          a_burst_tag_q  <= alloc_tag_c;
          a_beats_left_q <= a_beats - BEAT_W'(1);
        end
      end else begin
        a_beats_left_q <= a_beats_left_q - BEAT_W'(1);
        if (a_beats_left_q == BEAT_W'(1)) a_in_burst_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_TAGS; i++) src_tbl_q[i] <= '0;
    end else if (a_first) begin
      src_tbl_q[alloc_tag_c] <= in_a_source;
    end
  end

  // Per-tag D beat counters; beats on a free tag are forwarded but flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_TAGS; i++) d_cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else if (d_fire) begin
      if (d_tag_busy) begin
        d_cnt_q[out_d_source] <= d_last ? '0 : d_cnt_q[out_d_source] + BEAT_W'(1);
      end else begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_tl_source_shrinker.sv
// Directed and randomized checks of tl_source_shrinker against a cycle-level tag-pool model.
module tb_tl_source_shrinker;

  localparam int NT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        in_a_valid, in_a_ready;
  logic [2:0]  in_a_opcode, in_a_param;
  logic [3:0]  in_a_size;
  logic [5:0]  in_a_source;
  logic [63:0] in_a_address;
  logic [7:0]  in_a_mask;
  logic [63:0] in_a_data;
  logic        in_a_corrupt;

  logic        out_a_valid, out_a_ready;
  logic [2:0]  out_a_opcode, out_a_param;
  logic [3:0]  out_a_size;
  logic [1:0]  out_a_source;
  logic [63:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_a_corrupt;

  logic        out_d_valid, out_d_ready;
  logic [2:0]  out_d_opcode, out_d_param;
  logic [3:0]  out_d_size;
  logic [1:0]  out_d_source;
  logic [3:0]  out_d_sink;
  logic        out_d_denied;
  logic [63:0] out_d_data;
  logic        out_d_corrupt;

  logic        in_d_valid, in_d_ready;
  logic [2:0]  in_d_opcode, in_d_param;
  logic [3:0]  in_d_size;
  logic [5:0]  in_d_source;
  logic [3:0]  in_d_sink;
  logic        in_d_denied;
  logic [63:0] in_d_data;
  logic        in_d_corrupt;

  logic [2:0]  inflight_o;
  logic        err_o;

  tl_source_shrinker dut (
    .clk(clk), .rst_n(rst_n),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready), .in_a_opcode(in_a_opcode),
    .in_a_param(in_a_param), .in_a_size(in_a_size), .in_a_source(in_a_source),
    .in_a_address(in_a_address), .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .in_a_corrupt(in_a_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
    .out_d_corrupt(out_d_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready), .in_d_opcode(in_d_opcode),
    .in_d_param(in_d_param), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_sink(in_d_sink), .in_d_denied(in_d_denied), .in_d_data(in_d_data),
    .in_d_corrupt(in_d_corrupt),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Reference model: which tags are owned, who owns them, D beats seen per tag.
  bit [NT-1:0] m_busy;
  logic [5:0]  m_src [NT];
  int          m_dgot [NT];
  int          m_a_left;
  int          m_a_tag;
  bit          m_err;
  logic [2:0]  r_dop [NT];
  logic [3:0]  r_dsize [NT];

  int n_checks = 0;
  int n_errs   = 0;
  bit a_fired, d_fired;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int beats_of(input int size);
    return (size > 3) ? (1 << (size - 3)) : 1;
  endfunction

  task automatic idle();
    in_a_valid = 1'b0; out_d_valid = 1'b0;
    out_a_ready = 1'b1; in_d_ready = 1'b1;
  endtask

  task automatic set_a(input logic [2:0] op, input logic [3:0] size, input logic [5:0] src);
    in_a_valid = 1'b1; in_a_opcode = op; in_a_param = 3'd0; in_a_size = size;
    in_a_source = src; in_a_address = {$urandom, $urandom}; in_a_mask = 8'hFF;
    in_a_data = {$urandom, $urandom}; in_a_corrupt = 1'b0;
  endtask

  task automatic set_d(input logic [2:0] op, input logic [3:0] size, input int t,
                       input logic [63:0] data);
    out_d_valid = 1'b1; out_d_opcode = op; out_d_param = 3'd0; out_d_size = size;
    out_d_source = 2'(t); out_d_sink = 4'($urandom); out_d_denied = 1'b0;
    out_d_data = data; out_d_corrupt = 1'b0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit          any_free, open;
    int          tag, dt, need;
    bit [NT-1:0] nb;
    any_free = 1'b0; tag = 0;
    for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) begin any_free = 1'b1; tag = t; end
    open = (m_a_left > 0) || any_free;
    if (m_a_left > 0) tag = m_a_tag;
    #1;
    chk("out_a_valid", 64'(out_a_valid), 64'(in_a_valid && open));
    chk("in_a_ready", 64'(in_a_ready), 64'(out_a_ready && open));
    if (in_a_valid && open) begin
      chk("out_a_source", 64'(out_a_source), 64'(tag));
      chk("out_a_address", out_a_address, in_a_address);
      chk("out_a_data", out_a_data, in_a_data);
    end
    chk("in_d_valid", 64'(in_d_valid), 64'(out_d_valid));
    chk("out_d_ready", 64'(out_d_ready), 64'(in_d_ready));
    if (out_d_valid) begin
      chk("in_d_source", 64'(in_d_source), 64'(m_src[out_d_source]));
      chk("in_d_data", in_d_data, out_d_data);
      chk("in_d_opcode", 64'(in_d_opcode), 64'(out_d_opcode));
    end
    a_fired = in_a_valid && open && out_a_ready;
    d_fired = out_d_valid && in_d_ready;
    nb = m_busy;
    if (d_fired) begin
      dt = int'(out_d_source);
      if (!m_busy[dt]) m_err = 1'b1;
      else begin
        m_dgot[dt]++;
        need = (out_d_opcode == 3'd1) ? beats_of(int'(out_d_size)) : 1;
        if (m_dgot[dt] == need) begin m_dgot[dt] = 0; nb[dt] = 1'b0; end
      end
    end
    if (a_fired) begin
      if (m_a_left > 0) m_a_left--;
      else begin
        m_src[tag] = in_a_source;
        nb[tag] = 1'b1;
        if (in_a_opcode < 3'd4 && beats_of(int'(in_a_size)) > 1) begin
          m_a_left = beats_of(int'(in_a_size)) - 1;
          m_a_tag  = tag;
        end
      end
    end
    m_busy = nb;
    @(posedge clk); #1;
    chk("inflight_o", 64'(inflight_o), 64'($countones(m_busy)));
    chk("err_o", 64'(err_o), 64'(m_err));
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    m_busy = '0; m_a_left = 0; m_a_tag = 0; m_err = 1'b0;
    for (int t = 0; t < NT; t++) begin m_src[t] = '0; m_dgot[t] = 0; end
    #1;
    chk("rst_inflight", 64'(inflight_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_out_a_valid", 64'(out_a_valid), 64'd0);
    chk("rst_in_d_valid", 64'(in_d_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    int t;
    idle();
    set_a(3'd4, 4'd0, 6'd0); in_a_valid = 1'b0;
    set_d(3'd0, 4'd0, 0, 64'd0); out_d_valid = 1'b0;
    #2;
    do_reset();

    // 1: single Get round trip
    set_a(3'd4, 4'd3, 6'h1A);
    #1 chk("t1_tag", 64'(out_a_source), 64'd0);
    cycle();
    chk("t1_inflight", 64'(inflight_o), 64'd1);
    idle();
    set_d(3'd1, 4'd3, 0, 64'hDEADBEEF);
    #1 chk("t1_d_source", 64'(in_d_source), 64'h1A);
    chk("t1_d_data", in_d_data, 64'hDEADBEEF);
    cycle();
    chk("t1_freed", 64'(inflight_o), 64'd0);
    idle();

    // 2: fill the pool, block, then reuse a freed tag one cycle later
    for (int i = 0; i < 4; i++) begin
      set_a(3'd4, 4'd3, 6'((i * 17) + 1));
      #1 chk("t2_tag", 64'(out_a_source), 64'(i));
      cycle();
    end
    set_a(3'd4, 4'd3, 6'h05);
    #1 chk("t2_full_ready", 64'(in_a_ready), 64'd0);
    cycle();
    set_d(3'd0, 4'd0, 2, 64'd0);
    cycle();
    out_d_valid = 1'b0;
    #1 chk("t2_reuse_tag", 64'(out_a_source), 64'd2);
    chk("t2_reuse_ready", 64'(in_a_ready), 64'd1);
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin set_d(3'd0, 4'd0, i, 64'd0); cycle(); end
    idle();
    chk("t2_drained", 64'(inflight_o), 64'd0);

    // 3: 4-beat PutFull keeps one tag, with a stall in the middle
    set_a(3'd0, 4'd5, 6'h2B);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin out_a_ready = 1'b0; cycle(); out_a_ready = 1'b1; end
      in_a_data = {$urandom, $urandom};
      #1 chk("t3_beat_tag", 64'(out_a_source), 64'd0);
      cycle();
    end
    set_a(3'd4, 4'd3, 6'h3C);
    #1 chk("t3_get_tag", 64'(out_a_source), 64'd1);
    cycle();
    idle();
    set_d(3'd0, 4'd0, 0, 64'd0);
    #1 chk("t3_d_source", 64'(in_d_source), 64'h2B);
    cycle();
    set_d(3'd1, 4'd3, 1, 64'h1234);
    cycle();
    idle();

    // 4: 8-beat AccessAckData on tag 1 with in_d_ready stalls
    set_a(3'd4, 4'd3, 6'h11); cycle();
    set_a(3'd4, 4'd6, 6'h22);
    #1 chk("t4_tag", 64'(out_a_source), 64'd1);
    cycle();
    idle();
    beats = 0;
    for (int k = 0; k < 80 && beats < 8; k++) begin
      set_d(3'd1, 4'd6, 1, {$urandom, $urandom});
      in_d_ready = (k % 3) != 1;
      cycle();
      if (d_fired) begin
        beats++;
        if (beats < 8) chk("t4_busy_hold", 64'(inflight_o), 64'd2);
      end
    end
    chk("t4_beats", 64'(beats), 64'd8);
    chk("t4_freed", 64'(inflight_o), 64'd1);
    idle();
    set_d(3'd1, 4'd3, 0, 64'd0); cycle();
    idle();

    // 5: free and alloc in the same cycle
    set_a(3'd4, 4'd3, 6'h05); cycle();
    idle();
    set_d(3'd0, 4'd0, 0, 64'd0);
    set_a(3'd4, 4'd3, 6'h06);
    #1 chk("t5_tag", 64'(out_a_source), 64'd1);
    cycle();
    chk("t5_inflight", 64'(inflight_o), 64'd1);
    idle();
    set_d(3'd1, 4'd3, 1, 64'd0); cycle();
    idle();

    // Randomized traffic; D only targets owned tags with a stable per-message shape.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) != 0)
        set_a(3'($urandom_range(0, 5)), 4'($urandom_range(0, 6)), 6'($urandom));
      else in_a_valid = 1'b0;
      out_a_ready = ($urandom_range(0, 3) != 0);
      if (m_busy != '0 && $urandom_range(0, 2) != 0) begin
        t = int'($urandom_range(0, NT - 1));
        for (int g = 0; g < NT && !m_busy[t]; g++) t = (t + 1) % NT;
        if (m_dgot[t] == 0) begin
          r_dop[t]   = 3'($urandom_range(0, 1));
          r_dsize[t] = 4'($urandom_range(0, 5));
        end
        set_d(r_dop[t], r_dsize[t], t, {$urandom, $urandom});
      end else out_d_valid = 1'b0;
      in_d_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    chk("rand_no_err", 64'(err_o), 64'd0);
    do_reset();

    // 6: D on a free tag sets a sticky error; reset mid-burst clears everything
    set_d(3'd0, 4'd0, 3, 64'd0);
    cycle();
    chk("t6_err_set", 64'(err_o), 64'd1);
    idle();
    cycle(); cycle();
    chk("t6_err_sticky", 64'(err_o), 64'd1);
    set_a(3'd4, 4'd3, 6'h0A); cycle();
    set_a(3'd0, 4'd5, 6'h0F);
    #1 chk("t6_burst_tag", 64'(out_a_source), 64'd1);
    cycle(); cycle();
    do_reset();
    chk("t6_rst_err", 64'(err_o), 64'd0);
    chk("t6_rst_inflight", 64'(inflight_o), 64'd0);
    set_a(3'd4, 4'd3, 6'h11);
    #1 chk("t6_post_rst_tag0", 64'(out_a_source), 64'd0);
    cycle();
    set_a(3'd4, 4'd3, 6'h12);
    #1 chk("t6_post_rst_tag1", 64'(out_a_source), 64'd1);
    cycle();
    chk("t6_post_rst_inflight", 64'(inflight_o), 64'd2);
    idle();
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
